lfsr_4bit: RTL and testbench
============================

LFSR_4BIT -- requirements
Module: lfsr_4bit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: register width in bits; legal values 3..8.
REQ-002 The block SHALL have parameter SEED, default 1: the register value loaded on reset, WIDTH bits wide.
REQ-003 The block SHALL have port Clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port Rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port Out, output, WIDTH bits: the current LFSR state, driven directly from the state register.
REQ-006 The block SHALL have no other ports; it SHALL free-run with no enable, load or handshake signals.

Function
REQ-007 The block SHALL implement a Fibonacci (external-XOR) LFSR whose feedback polynomial gives maximal length for the selected WIDTH.
REQ-008 On each rising Clk edge with Rst low, the next state SHALL be {Out[WIDTH-2:0], fb}: a left shift with the feedback bit fb entering at bit 0.
REQ-009 fb SHALL be the XOR of the tap bits Out[t-1] for each tap t listed for WIDTH.
REQ-010 The tap sets SHALL be: W3 {3,2}; W4 {4,3}; W5 {5,3}; W6 {6,5}; W7 {7,6}; W8 {8,6,5,4}.
REQ-011 For the default WIDTH=4, fb SHALL equal Out[3] XOR Out[2] (polynomial x^4+x^3+1).
REQ-012 The sequence period SHALL be 2^WIDTH-1 (15 for WIDTH=4) and SHALL cover every nonzero value exactly once per period.
REQ-013 With WIDTH=4 and SEED=1, the sequence after reset SHALL be 1,2,4,9,3,6,13,10,5,11,7,15,14,12,8, then repeat from 1.
REQ-014 Latency: Out SHALL change one clock after each rising edge's sampled state, with one state step per rising edge and no pipeline delay.
REQ-015 Lockup guard: if the register ever holds all zeros, the next state on the following edge SHALL be the effective seed.
REQ-016 Effective seed SHALL be SEED truncated to WIDTH bits; if that value is zero, the effective seed SHALL be 1.
REQ-017 An illegal WIDTH (outside 3..8) SHALL cause an elaboration-time error.

Reset
REQ-018 When Rst is high, Out SHALL take the effective seed immediately, without waiting for a clock edge (WIDTH=4 default: 4'b0001).
REQ-019 Out SHALL hold the effective seed for as long as Rst stays high, regardless of Clk activity.
REQ-020 On Rst deassertion, the first rising Clk edge SHALL advance the state exactly one step from the seed (0001 -> 0010 for the default).
REQ-021 Reset asserted mid-sequence SHALL abort the sequence asynchronously and restart it from the seed after release.

Verification
REQ-022 The bench SHALL cover power-on reset: Rst=1 for 2 clocks, then release -> Out=1 during reset, then 2,4,9,3 on the next 4 rising edges.
REQ-023 The bench SHALL cover a full period: 20 rising edges after release -> Out follows the REQ-013 list, equals 1 again at edge 15, and shows 2,4,9,3,6 at edges 16-20.
REQ-024 The bench SHALL cover asynchronous reset: pulse Rst between clock edges when Out=13 -> Out=1 before the next edge, and the sequence resumes 2,4,...
REQ-025 The bench SHALL cover the lockup guard: force the register to 0 and release -> the next edge gives Out=1.
REQ-026 The bench SHALL cover parameter sweeps: WIDTH=3 with SEED=0 -> reset value 1 and period 7; WIDTH=8 with SEED=8'hA5 -> reset value A5 and period 255 with no repeat before it.
REQ-027 The bench SHALL check a uniqueness scoreboard for every WIDTH 3..8: no value repeats within 2^WIDTH-1 steps, and 0 never appears.

Source files
------------

// File: rtl/lfsr_4bit.sv
// lfsr_4bit: free-running Fibonacci (external-XOR) LFSR with maximal-length
// taps for WIDTH 3..8.
//
// Ports:
//   Clk  - clock; the state advances one step per rising edge
//   Rst  - asynchronous, active-high reset; loads the effective seed at once
//   Out  - current LFSR state, driven straight from the state register
//
// Parameters:
//   WIDTH - register width, legal 3..8
//   SEED  - reset value; an all-zero seed is replaced by 1 because zero is
//           the one state a XOR-feedback LFSR can never leave
module lfsr_4bit #(
  parameter int unsigned      WIDTH = 4,
  parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             Clk,
  input  logic             Rst,
  output logic [WIDTH-1:0] Out
);

  // Tap mask for each width: bit (t-1) is set for every tap t.
  //   W3 {3,2}  W4 {4,3}  W5 {5,3}  W6 {6,5}  W7 {7,6}  W8 {8,6,5,4}
  function automatic logic [7:0] tap_mask(input int unsigned w);
    logic [7:0] m;
    m = 8'h00;
    case (w)
      3:       m = 8'b0000_0110;
      4:       m = 8'b0000_1100;
      5:       m = 8'b0001_0100;
      6:       m = 8'b0011_0000;
      7:       m = 8'b0110_0000;
      8:       m = 8'b1011_1000;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

  localparam logic [7:0]       TAP_MASK8 = tap_mask(WIDTH);
  localparam logic [WIDTH-1:0] TAPS      = TAP_MASK8[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] EFF_SEED  = (SEED == '0) ? ONE : SEED;

  generate
    if (WIDTH < 3 || WIDTH > 8) begin : g_bad_width
      $error("lfsr_4bit: WIDTH must be in 3..8");
    end
  endgenerate

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic             fb;

  always_comb begin
    fb      = ^(state_q & TAPS);
    state_d = {state_q[WIDTH-2:0], fb};
    // All-zero is a fixed point of the feedback; kick it back to the seed.
    if (state_q == '0) state_d = EFF_SEED;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state_q <= EFF_SEED;
    else     state_q <= state_d;
  end

  assign Out = state_q;

endmodule

// File: tb/tb_lfsr_4bit.sv
module tb_lfsr_4bit;

  logic       clk;
  logic       rst;
  logic [2:0] out3;
  logic [3:0] out4;
  logic [4:0] out5;
  logic [5:0] out6;
  logic [6:0] out7;
  logic [7:0] out8;

  int errors = 0;
  int checks = 0;

  lfsr_4bit dut (.Clk(clk), .Rst(rst), .Out(out4));
  lfsr_4bit #(.WIDTH(3), .SEED(3'd0))   u_w3 (.Clk(clk), .Rst(rst), .Out(out3));
  lfsr_4bit #(.WIDTH(5))                u_w5 (.Clk(clk), .Rst(rst), .Out(out5));
  lfsr_4bit #(.WIDTH(6))                u_w6 (.Clk(clk), .Rst(rst), .Out(out6));
  lfsr_4bit #(.WIDTH(7))                u_w7 (.Clk(clk), .Rst(rst), .Out(out7));
  lfsr_4bit #(.WIDTH(8), .SEED(8'hA5))  u_w8 (.Clk(clk), .Rst(rst), .Out(out8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] exp;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int get_out(input int w);
    case (w)
      3: return int'(out3);
      4: return int'(out4);
      5: return int'(out5);
      6: return int'(out6);
      7: return int'(out7);
      default: return int'(out8);
    endcase
  endfunction

  function automatic int seed_of(input int w);
    if (w == 8) return 'hA5;
    return 1;
  endfunction

  // Hand-computed WIDTH=4, SEED=1 sequence.
  int   seq [15] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8};
  vec_t vecs [22];

  initial begin
    bit [255:0] seen [3:8];
    int dup_err [3:8];
    int zero_err[3:8];
    int period, v;

    // Table: 2 clocks in reset, then 20 free-running edges.
    vecs[0] = '{1'b1, 4'd1};
    vecs[1] = '{1'b1, 4'd1};
    for (int k = 0; k < 20; k++) vecs[2+k] = '{1'b0, 4'(seq[(k+1) % 15])};

    rst = 1'b0;
    #2 rst = 1'b1;
    #1 check("async_por", out4, 1);   // before any clock edge

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      rst = vecs[i].rst;
      @(posedge clk);
      #1 check($sformatf("vec%0d", i), out4, vecs[i].exp);
    end

    // Mid-sequence async reset at Out=13.
    @(posedge clk);
    #1 check("pre_reset_13", out4, 13);
    #1 rst = 1'b1;
    #1 check("async_mid", out4, 1);
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1 check($sformatf("resume%0d", k), out4, seq[k]);
    end

    // Lockup guard: force the register to zero, then let it run.
    @(negedge clk);
    force dut.state_q = 4'd0;
    #1 check("forced_zero", out4, 0);
    release dut.state_q;
    @(posedge clk);
    #1 check("lockup_recover", out4, 1);
    @(posedge clk);
    #1 check("lockup_next", out4, 2);

    // Width sweep: reset all, then 255 edges with a uniqueness scoreboard.
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int w = 3; w <= 8; w++) begin
      check($sformatf("w%0d_reset", w), get_out(w), seed_of(w));
      seen[w]     = '0;
      seen[w][seed_of(w)] = 1'b1;
      dup_err[w]  = 0;
      zero_err[w] = 0;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 255; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        check("w3_step1", out3, 2);
        check("w8_step1", out8, 'h4A);
      end
      if (i == 2) check("w3_step2", out3, 5);
      for (int w = 3; w <= 8; w++) begin
        period = (1 << w) - 1;
        v = get_out(w);
        if (i < period) begin
          if (v == 0) zero_err[w]++;
          if (seen[w][v]) dup_err[w]++;
          seen[w][v] = 1'b1;
        end else if (i == period) begin
          check($sformatf("w%0d_period", w), v, seed_of(w));
        end
      end
    end
    for (int w = 3; w <= 8; w++) begin
      check($sformatf("w%0d_no_repeat", w), dup_err[w], 0);
      check($sformatf("w%0d_no_zero", w), zero_err[w], 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
